// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-based debounce.
//   clk       - system clock, rising edge
//   rst       - asynchronous reset, active-low
//   rows[3:0] - keypad row lines, active-high, externally pulled down
//   cols[3:0] - one-hot column drive, active-high
//   key_code  - code of last accepted key (col_index*4 + row_index)
//   key_valid - one-clock pulse per accepted press
//   key_held  - high while the accepted key is considered down
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    acc_n_q, acc_n_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;

    logic          slot_end, frame_end;
    logic [2:0]    pop, tot;
    logic [1:0]    row_idx, n_new;
    logic [3:0]    code_new, cnt_inc;

    always_comb begin
        slot_end = slot_q == SLOT_LAST;
        frame_end = slot_end && col_q == 2'd3;
        slot_d = slot_end ? '0 : slot_q + 1'b1;
        col_d = slot_end ? col_q + 2'd1 : col_q;
        pop = {2'b0, sync2_q[0]} + {2'b0, sync2_q[1]} + {2'b0, sync2_q[2]} + {2'b0, sync2_q[3]};
        row_idx = sync2_q[1] ? 2'd1 : sync2_q[2] ? 2'd2 : sync2_q[3] ? 2'd3 : 2'd0;
        // Row-bit tally across the frame saturates at 2, which already means MULTI.
        tot = {1'b0, acc_n_q} + pop;
        n_new = tot >= 3'd2 ? 2'd2 : tot[1:0];
        code_new = (acc_n_q == 2'd0 && pop == 3'd1) ? {col_q, row_idx} : acc_code_q;
        acc_n_d = slot_end ? (frame_end ? 2'd0 : n_new) : acc_n_q;
        acc_code_d = slot_end ? (frame_end ? 4'd0 : code_new) : acc_code_q;
        cnt_inc = cnt_q >= DB ? cnt_q : cnt_q + 4'd1;
        state_d = state_q;
        cnt_d = cnt_q;
        cand_d = cand_q;
        code_d = code_q;
        valid_d = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: if (n_new == 2'd1) begin
                    cand_d = code_new;
                    cnt_d = 4'd1;
                    state_d = PRESS_WAIT;
                end
                PRESS_WAIT: if (n_new != 2'd1) begin
                    cnt_d = 4'd0;
                    state_d = IDLE;
                end else if (code_new != cand_q) begin
                    cand_d = code_new;
                    cnt_d = 4'd1;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB) begin
                        state_d = HELD;
                        code_d = cand_q;
                        valid_d = 1'b1;
                    end
                end
                HELD: if (n_new == 2'd0) begin
                    cnt_d = 4'd1;
                    state_d = REL_WAIT;
                end
                REL_WAIT: if (n_new != 2'd0) begin
                    cnt_d = 4'd0;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            slot_q <= '0;
            col_q <= '0;
            acc_n_q <= '0;
            acc_code_q <= '0;
            cand_q <= '0;
            cnt_q <= '0;
            code_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rows;
            sync2_q <= sync1_q;
            slot_q <= slot_d;
            col_q <= col_d;
            acc_n_q <= acc_n_d;
            acc_code_q <= acc_code_d;
            cand_q <= cand_d;
            cnt_q <= cnt_d;
            code_q <= code_d;
            valid_q <= valid_d;
        end
    end

    assign cols = 4'b0001 << col_q;
    assign key_code = code_q;
    assign key_valid = valid_q;
    assign key_held = state_q == HELD || state_q == REL_WAIT;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed frame stimulus against a run-length reference model.
module tb_keypad_scanner;
    localparam int SC = 8;
    localparam int D = 3;
    localparam int FR = 4 * SC;

    logic clk = 1'b0, rst = 1'b0;
    logic [3:0] rows, cols, key_code;
    logic key_valid, key_held;
    logic [15:0] mask = '0;
    int checks = 0, errors = 0, n = 0;
    int run = 0, run_code = 0, none_run = 0, exp_code = 0;
    bit m_held = 0, exp_valid = 0;

    keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(D)) dut (
        .clk(clk), .rst(rst), .rows(rows), .cols(cols),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = '0;
        for (int c = 0; c < 4; c++) if (cols[c]) rows = rows | mask[c*4 +: 4];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t n=%0d got %0h exp %0h", tag, $time, n, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; run = 0; run_code = 0; none_run = 0; exp_code = 0; m_held = 0; exp_valid = 0;
    endtask

    task automatic eval(input logic [15:0] m);
        int pc, code;
        pc = $countones(m);
        code = 0;
        for (int i = 0; i < 16; i++) if (m[i]) code = i;
        if (!m_held) begin
            if (pc == 1) begin
                if (run > 0 && code == run_code) run++;
                else begin
                    run = 1;
                    run_code = code;
                end
                if (run == D) begin
                    m_held = 1;
                    exp_valid = 1;
                    exp_code = run_code;
                    none_run = 0;
                end
            end else run = 0;
        end else if (pc == 0) begin
            none_run++;
            if (none_run == D) begin
                m_held = 0;
                run = 0;
            end
        end else none_run = 0;
    endtask

    task automatic check_outs();
        check("cols", 32'(cols), 32'(1) << ((n / SC) % 4));
        check("key_valid", 32'(key_valid), 32'(exp_valid));
        check("key_held", 32'(key_held), 32'(m_held));
        check("key_code", 32'(key_code), 32'(exp_code));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        exp_valid = 0;
        if (n % FR == 0) eval(mask);
        check_outs();
    endtask

    task automatic frames(input logic [15:0] m, input int k);
        mask = m;
        repeat (k * FR) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_outs();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outs();
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    localparam logic [15:0] K0 = 16'h0001, K5 = 16'h0020, K6 = 16'h0040;

    initial begin
        logic [15:0] prev;
        int r;
        do_reset();
        frames(0, 1);
        frames(K6, 5);
        frames(0, 4);
        frames(K6, 1); frames(0, 1); frames(K6, 3); frames(0, 4);
        frames(K0 | K5, 4); frames(K5, 3); frames(0, 4);
        frames(K6, 3); frames(0, 2); frames(K6, 1); frames(0, 4);
        frames(K6, 2);
        repeat (FR / 3) step();
        do_reset();
        frames(K6, 4); frames(0, 4);
        prev = 0;
        repeat (70) begin
            r = $urandom_range(0, 99);
            if (r < 45) mask = prev;
            else if (r < 65) mask = 0;
            else if (r < 90) mask = 16'(1) << $urandom_range(0, 15);
            else mask = (16'(1) << $urandom_range(0, 7)) | (16'(1) << $urandom_range(8, 15));
            prev = mask;
            frames(mask, 1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
